// File: rtl/wb_vmemem_pkg.sv
// Shared definitions for the Wishbone to VME-memory register bridge.
// Holds the bridge FSM state encoding, the timeout counter width and the
// default timeout value used by the top level and the timer.
package wb_vmemem_pkg;

    // Width of the wait counter; TIMEOUT must fit into it.
    localparam int unsigned CNT_W           = 16;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

endpackage : wb_vmemem_pkg

// File: rtl/wb_vmemem_timer.sv
// Wait-cycle counter for the bridge.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   clear_i     - reset the count to zero (start of a transfer)
//   enable_i    - count one more cycle without a matching Done
//   expired_o   - the coming enabled cycle is the TIMEOUT-th one
module wb_vmemem_timer
    import wb_vmemem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // The counter holds the number of cycles already waited, so the
    // TIMEOUT-th wait cycle is the one that sees TIMEOUT-1 here.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule : wb_vmemem_timer

// File: rtl/wb_vmemem_bridge.sv
// Wishbone classic slave that forwards single word accesses to a VME
// register block using one-cycle Rd/Wr strobes and Done handshakes.
// Ports:
//   clk, rst_n            - clock and synchronous active-low reset
//   wb_cyc_i .. wb_dat_i  - Wishbone request
//   wb_dat_o, wb_ack_o,
//   wb_err_o              - registered Wishbone response (err = timeout)
//   VMEAddr, VMEWrData    - latched address / write data to the block
//   VMERdMem, VMEWrMem    - one-cycle access strobes
//   VMERdData, VMERdDone,
//   VMEWrDone             - completion from the block
module wb_vmemem_bridge
    import wb_vmemem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [ADDR_W-1:0] VMEAddr,
    output logic [31:0]       VMEWrData,
    output logic              VMERdMem,
    output logic              VMEWrMem,
    input  logic [31:0]       VMERdData,
    input  logic              VMERdDone,
    input  logic              VMEWrDone
);

    state_t            state_q, state_d;
    logic [31:0]       dat_q, dat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdat_q, wdat_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              rdmem_q, rdmem_d;
    logic              wrmem_q, wrmem_d;
    logic              abort_q, abort_d;
    logic              abort_s;
    logic              tmr_clear_s;
    logic              tmr_en_s;
    logic              tmr_expired_s;

    wb_vmemem_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (tmr_clear_s),
        .enable_i  (tmr_en_s),
        .expired_o (tmr_expired_s)
    );

    // A master that drops cyc in the very cycle Done arrives has
    // abandoned the transfer too, so the live cyc is folded in here.
    assign abort_s = abort_q | ~wb_cyc_i;

    // Next state and registered output values.
    always_comb begin
        state_d     = state_q;
        dat_d       = dat_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rdmem_d     = 1'b0;
        wrmem_d     = 1'b0;
        abort_d     = abort_q;
        tmr_clear_s = 1'b0;
        tmr_en_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_d      = wb_adr_i;
                    wdat_d      = wb_dat_i;
                    rdmem_d     = ~wb_we_i;
                    wrmem_d     = wb_we_i;
                    abort_d     = 1'b0;
                    tmr_clear_s = 1'b1;
                    state_d     = wb_we_i ? ST_WR_WAIT : ST_RD_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                abort_d = abort_s;
                if (VMERdDone) begin
                    dat_d   = VMERdData;
                    ack_d   = ~abort_s;
                    state_d = ST_RESP;
                end else if (tmr_expired_s) begin
                    err_d   = ~abort_s;
                    state_d = ST_RESP;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            ST_WR_WAIT: begin
                abort_d = abort_s;
                if (VMEWrDone) begin
                    ack_d   = ~abort_s;
                    state_d = ST_RESP;
                end else if (tmr_expired_s) begin
                    err_d   = ~abort_s;
                    state_d = ST_RESP;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            ST_RESP: begin
                // Strobes seen here are deliberately ignored.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dat_q   <= 32'h0000_0000;
            addr_q  <= {ADDR_W{1'b0}};
            wdat_q  <= 32'h0000_0000;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdmem_q <= 1'b0;
            wrmem_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdmem_q <= rdmem_d;
            wrmem_q <= wrmem_d;
            abort_q <= abort_d;
        end
    end

    assign wb_dat_o  = dat_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign VMEAddr   = addr_q;
    assign VMEWrData = wdat_q;
    assign VMERdMem  = rdmem_q;
    assign VMEWrMem  = wrmem_q;

endmodule : wb_vmemem_bridge
